issue_queue: RTL and testbench



---
 rtl/issue_queue_pkg.sv | 24 ++
 rtl/issue_queue_ram.sv | 29 ++
 rtl/issue_queue.sv | 63 ++++++
 tb/tb_issue_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Public_Info: shared decode/issue types plus the dual-issue pairing rule.
package Public_Info;
  localparam logic [9:0] INST_ALU  = 10'h001;
  localparam logic [9:0] INST_MUL  = 10'h004;
  localparam logic [9:0] INST_DIV  = 10'h008;
  localparam logic [9:0] INST_ERTN = 10'h020;
  typedef struct packed {
    logic        o_valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [9:0]  inst_type;
    logic [2:0]  csr_type;
    logic        rf_we;
    logic [4:0]  rf_rd, rf_raddr1, rf_raddr2;
  } PC_set;
  // a is the older instruction, b the younger
  function automatic logic pair_can_dual(PC_set a, PC_set b);
    logic raw, non_alu, serial;
    raw = a.rf_we && a.rf_rd != 5'd0 && (a.rf_rd == b.rf_raddr1 || a.rf_rd == b.rf_raddr2);
    non_alu = a.inst_type != INST_ALU && b.inst_type != INST_ALU;
    serial = a.inst_type == INST_ERTN || b.inst_type == INST_ERTN || a.csr_type != 3'd0 || b.csr_type != 3'd0;
    return !(raw || non_alu || serial);
  endfunction
endpackage

// File: rtl/issue_queue_ram.sv
// iq_ram: entry storage with two write ports and two asynchronous read ports.
module iq_ram import Public_Info::*; #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we1_i,
  input  logic [PTR_W-1:0] wa1_i,
  input  PC_set            wd1_i,
  input  logic             we2_i,
  input  logic [PTR_W-1:0] wa2_i,
  input  PC_set            wd2_i,
  input  logic [PTR_W-1:0] ra1_i,
  input  logic [PTR_W-1:0] ra2_i,
  output PC_set            rd1_o,
  output PC_set            rd2_o
);
  PC_set mem_q [DEPTH];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) mem_q <= '{default: '0};
    else begin
      if (we1_i) mem_q[wa1_i] <= wd1_i;
      if (we2_i) mem_q[wa2_i] <= wd2_i;
    end
  end
  assign rd1_o = mem_q[ra1_i];
  assign rd2_o = mem_q[ra2_i];
endmodule

// File: rtl/issue_queue.sv
// issue_queue: in-order dual-ported queue between decode and issue; picks
// dual/single/no issue each cycle and pops accordingly, with flush and stall.
module issue_queue import Public_Info::*; #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  PC_set          d_set1,
  input  PC_set          d_set2,
  output logic           d_ready,
  input  logic           flush_BR,
  input  logic           stall_DCache,
  input  logic           stall_div,
  output PC_set          i_set1,
  output PC_set          i_set2,
  output logic [PTR_W:0] q_count
);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0] count_q, count_d, n_push, n_pop;
  logic stall, we1, we2, v1, v2;
  PC_set e1, e2;
  assign stall = stall_DCache | stall_div;
  assign d_ready = count_q <= READY_MAX;
  assign we1 = d_ready & ~flush_BR & d_set1.o_valid;
  assign we2 = we1 & d_set2.o_valid;
  assign n_push = (PTR_W+1)'(we1) + (PTR_W+1)'(we2);
  iq_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk(clk), .rstn(rstn),
    .we1_i(we1), .wa1_i(tail_q), .wd1_i(d_set1),
    .we2_i(we2), .wa2_i(tail_q + PTR_W'(1)), .wd2_i(d_set2),
    .ra1_i(head_q), .ra2_i(head_q + PTR_W'(1)),
    .rd1_o(e1), .rd2_o(e2)
  );
  assign v1 = count_q != '0 & ~flush_BR;
  assign v2 = count_q >= (PTR_W+1)'(2) & ~flush_BR & pair_can_dual(e1, e2);
  always_comb begin
    i_set1 = e1;
    i_set1.o_valid = v1;
    i_set2 = e2;
    i_set2.o_valid = v2;
  end
  assign n_pop = stall ? '0 : (PTR_W+1)'(v1) + (PTR_W+1)'(v2);
  assign head_d = flush_BR ? '0 : head_q + n_pop[PTR_W-1:0];
  assign tail_d = flush_BR ? '0 : tail_q + n_push[PTR_W-1:0];
  assign count_d = flush_BR ? '0 : count_q + n_push - n_pop;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  assign q_count = count_q;
  a_count_max: assert property (@(posedge clk) disable iff (!rstn) count_q <= DEPTH_C);
  a_pop_max: assert property (@(posedge clk) disable iff (!rstn) n_pop <= count_q);
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed scenarios plus randomized traffic against a
// queue-based reference model of the issue queue.
module tb_issue_queue;
  import Public_Info::*;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  logic clk = 0, rstn = 0, flush_BR = 0, stall_DCache = 0, stall_div = 0, d_ready;
  PC_set d_set1 = '0, d_set2 = '0, i_set1, i_set2;
  logic [PTR_W:0] q_count;
  int n_vec = 0, n_err = 0;
  logic [31:0] pc_ctr = 32'h1000;
  PC_set mq[$];

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .d_set1(d_set1), .d_set2(d_set2), .d_ready(d_ready),
    .flush_BR(flush_BR), .stall_DCache(stall_DCache), .stall_div(stall_div),
    .i_set1(i_set1), .i_set2(i_set2), .q_count(q_count)
  );
  always #5 clk = ~clk;

  function automatic PC_set mk(logic [9:0] t, logic we, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2, logic [2:0] csr);
    PC_set e = '0;
    e.o_valid = 1;
    e.pc = pc_ctr;
    pc_ctr += 4;
    e.inst = $urandom;
    e.inst_type = t;
    e.csr_type = csr;
    e.rf_we = we;
    e.rf_rd = rd;
    e.rf_raddr1 = r1;
    e.rf_raddr2 = r2;
    return e;
  endfunction

  function automatic PC_set mk_rnd(bit valid);
    int k = $urandom_range(0, 9);
    logic [9:0] t = k < 6 ? 10'h001 : k == 6 ? 10'h004 : k == 7 ? 10'h008 : k == 8 ? 10'h020 : 10'h002;
    PC_set e = mk(t, 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 7) == 0 ? 3'($urandom_range(1, 7)) : 3'd0);
    e.o_valid = valid;
    return e;
  endfunction

  // Pairing rule: older writer feeding the younger, two non-ALU ops, or any ertn/CSR op.
  function automatic bit ref_dual(PC_set o, PC_set y);
    if (o.rf_we && o.rf_rd != 0 && (y.rf_raddr1 == o.rf_rd || y.rf_raddr2 == o.rf_rd)) return 0;
    if (o.inst_type != 10'h001 && y.inst_type != 10'h001) return 0;
    if (o.inst_type == 10'h020 || y.inst_type == 10'h020 || o.csr_type != 0 || y.csr_type != 0) return 0;
    return 1;
  endfunction
  function automatic bit ev1(); return mq.size() >= 1 && !flush_BR; endfunction
  function automatic bit ev2(); return mq.size() >= 2 && !flush_BR && ref_dual(mq[0], mq[1]); endfunction
  function automatic logic [PTR_W:0] ecnt(); return (PTR_W+1)'(mq.size()); endfunction

  task automatic idle();
    d_set1 = '0; d_set2 = '0; flush_BR = 0; stall_DCache = 0; stall_div = 0;
  endtask

  task automatic cycle();
    bit fl = flush_BR;
    bit rdy = mq.size() <= DEPTH - 2;
    int np = (stall_DCache || stall_div) ? 0 : int'(ev1()) + int'(ev2());
    PC_set a = d_set1, b = d_set2;
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      repeat (np) void'(mq.pop_front());
      if (rdy && a.o_valid) begin
        mq.push_back(a);
        if (b.o_valid) mq.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    repeat (2) @(negedge clk);
    rstn = 1;
    #1;
    n_vec += 4;
    if (d_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", d_ready); end
    if (q_count !== 0) begin n_err++; $display("FAIL reset_count: got %0d want 0", q_count); end
    if (i_set1.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_v1: got %b want 0", i_set1.o_valid); end
    if (i_set2.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_v2: got %b want 0", i_set2.o_valid); end
  endtask

  task automatic test_dual_alu();
    PC_set a = mk(10'h001, 1, 5, 1, 2, 0), b = mk(10'h001, 1, 6, 1, 2, 0);
    d_set1 = a; d_set2 = b;
    #1;
    n_vec++;
    if (i_set1.o_valid !== 1'b0) begin n_err++; $display("FAIL dual_nobypass: got %b want 0", i_set1.o_valid); end
    cycle(); idle(); #1;
    n_vec += 4;
    if (i_set1 !== a) begin n_err++; $display("FAIL dual_set1: got %h want %h", i_set1, a); end
    if (i_set2 !== b) begin n_err++; $display("FAIL dual_set2: got %h want %h", i_set2, b); end
    if (q_count !== 2) begin n_err++; $display("FAIL dual_cnt2: got %0d want 2", q_count); end
    cycle(); #1;
    if (q_count !== 0) begin n_err++; $display("FAIL dual_cnt0: got %0d want 0", q_count); end
  endtask

  task automatic test_raw();
    PC_set a = mk(10'h001, 1, 7, 1, 2, 0), b = mk(10'h001, 1, 8, 7, 3, 0);
    d_set1 = a; d_set2 = b;
    cycle(); idle(); #1;
    n_vec += 6;
    if (i_set1.o_valid !== 1'b1 || i_set1.pc !== a.pc) begin n_err++; $display("FAIL raw_v1: got %b/%h want 1/%h", i_set1.o_valid, i_set1.pc, a.pc); end
    if (i_set2.o_valid !== 1'b0) begin n_err++; $display("FAIL raw_v2: got %b want 0", i_set2.o_valid); end
    cycle(); #1;
    if (q_count !== 1) begin n_err++; $display("FAIL raw_cnt1: got %0d want 1", q_count); end
    if (i_set1.o_valid !== 1'b1 || i_set1.pc !== b.pc) begin n_err++; $display("FAIL raw_second: got %b/%h want 1/%h", i_set1.o_valid, i_set1.pc, b.pc); end
    if (i_set2.o_valid !== 1'b0) begin n_err++; $display("FAIL raw_single_v2: got %b want 0", i_set2.o_valid); end
    cycle(); #1;
    if (q_count !== 0) begin n_err++; $display("FAIL raw_cnt0: got %0d want 0", q_count); end
  endtask

  task automatic test_nonalu();
    PC_set a = mk(10'h008, 1, 9, 1, 2, 0), b = mk(10'h004, 1, 10, 3, 4, 0);
    d_set1 = a; d_set2 = b;
    cycle(); idle(); #1;
    n_vec += 6;
    if (i_set1.pc !== a.pc || i_set2.o_valid !== 1'b0) begin n_err++; $display("FAIL nonalu_first: got %h/%b want %h/0", i_set1.pc, i_set2.o_valid, a.pc); end
    cycle(); #1;
    if (i_set1.pc !== b.pc || i_set1.o_valid !== 1'b1 || i_set2.o_valid !== 1'b0) begin n_err++; $display("FAIL nonalu_second: got %h/%b/%b want %h/1/0", i_set1.pc, i_set1.o_valid, i_set2.o_valid, b.pc); end
    if (q_count !== 1) begin n_err++; $display("FAIL nonalu_cnt: got %0d want 1", q_count); end
    cycle();
    d_set1 = mk(10'h001, 1, 0, 1, 2, 0); d_set2 = mk(10'h001, 1, 11, 0, 0, 0);
    cycle(); idle(); #1;
    if (i_set2.o_valid !== 1'b1) begin n_err++; $display("FAIL rd0_dual: got %b want 1", i_set2.o_valid); end
    if (q_count !== 2) begin n_err++; $display("FAIL rd0_cnt2: got %0d want 2", q_count); end
    cycle(); #1;
    if (q_count !== 0) begin n_err++; $display("FAIL rd0_cnt0: got %0d want 0", q_count); end
  endtask

  task automatic test_full();
    stall_div = 1;
    for (int i = 0; i < 4; i++) begin
      d_set1 = mk(10'h001, 1, 5'(12 + 2 * i), 0, 0, 0);
      d_set2 = i < 3 ? mk(10'h001, 1, 5'(13 + 2 * i), 0, 0, 0) : '0;
      cycle();
    end
    #1;
    n_vec += 3;
    if (q_count !== 7) begin n_err++; $display("FAIL full_cnt7: got %0d want 7", q_count); end
    if (d_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", d_ready); end
    d_set1 = mk(10'h001, 1, 20, 0, 0, 0); d_set2 = mk(10'h001, 1, 21, 0, 0, 0);
    cycle(); #1;
    if (q_count !== 7) begin n_err++; $display("FAIL full_drop: got %0d want 7", q_count); end
    idle(); #1;
    n_vec += 3;
    if (i_set1.o_valid !== 1'b1 || i_set2.o_valid !== 1'b1) begin n_err++; $display("FAIL full_pop: got %b%b want 11", i_set1.o_valid, i_set2.o_valid); end
    cycle(); #1;
    if (d_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_back: got %b want 1", d_ready); end
    if (q_count !== 5) begin n_err++; $display("FAIL full_cnt5: got %0d want 5", q_count); end
    repeat (12) begin
      d_set1 = mk(10'h001, 1, 22, 0, 0, 0); d_set2 = mk(10'h001, 1, 23, 0, 0, 0);
      #1;
      n_vec += 2;
      if (i_set1.pc !== mq[0].pc || i_set2.pc !== mq[1].pc) begin n_err++; $display("FAIL wrap_order: got %h/%h want %h/%h", i_set1.pc, i_set2.pc, mq[0].pc, mq[1].pc); end
      if (q_count !== ecnt()) begin n_err++; $display("FAIL wrap_cnt: got %0d want %0d", q_count, ecnt()); end
      cycle();
    end
    idle();
    repeat (6) cycle();
    #1;
    n_vec++;
    if (q_count !== 0) begin n_err++; $display("FAIL wrap_drain: got %0d want 0", q_count); end
  endtask

  task automatic test_stall();
    PC_set s1, s2;
    logic [31:0] first_pc = pc_ctr;
    stall_div = 1;
    repeat (2) begin
      d_set1 = mk(10'h001, 1, 24, 0, 0, 0); d_set2 = mk(10'h001, 1, 25, 0, 0, 0);
      cycle();
    end
    d_set1 = '0; d_set2 = '0;
    #1;
    s1 = i_set1; s2 = i_set2;
    for (int i = 0; i < 3; i++) begin
      cycle(); #1;
      n_vec += 3;
      if (i_set1 !== s1) begin n_err++; $display("FAIL stall_set1_%0d: got %h want %h", i, i_set1, s1); end
      if (i_set2 !== s2) begin n_err++; $display("FAIL stall_set2_%0d: got %h want %h", i, i_set2, s2); end
      if (q_count !== 4) begin n_err++; $display("FAIL stall_cnt_%0d: got %0d want 4", i, q_count); end
    end
    stall_div = 0;
    #1;
    n_vec++;
    if (i_set1.pc !== first_pc) begin n_err++; $display("FAIL stall_release: got %h want %h", i_set1.pc, first_pc); end
    repeat (4) begin
      cycle(); #1;
      n_vec++;
      if (q_count !== ecnt() || (mq.size() > 0 && i_set1.pc !== mq[0].pc)) begin n_err++; $display("FAIL stall_resume: got %0d/%h want %0d", q_count, i_set1.pc, ecnt()); end
    end
  endtask

  task automatic test_flush();
    stall_div = 1;
    for (int i = 0; i < 3; i++) begin
      d_set1 = mk(10'h001, 1, 26, 0, 0, 0);
      d_set2 = i < 2 ? mk(10'h001, 1, 27, 0, 0, 0) : '0;
      cycle();
    end
    stall_div = 0; flush_BR = 1;
    d_set1 = mk(10'h001, 1, 28, 0, 0, 0); d_set2 = mk(10'h001, 1, 29, 0, 0, 0);
    #1;
    n_vec += 6;
    if (q_count !== 5) begin n_err++; $display("FAIL flush_pre_cnt: got %0d want 5", q_count); end
    if (i_set1.o_valid !== 1'b0 || i_set2.o_valid !== 1'b0) begin n_err++; $display("FAIL flush_outs: got %b%b want 00", i_set1.o_valid, i_set2.o_valid); end
    cycle(); idle(); #1;
    if (q_count !== 0) begin n_err++; $display("FAIL flush_cnt: got %0d want 0", q_count); end
    if (i_set1.o_valid !== 1'b0) begin n_err++; $display("FAIL flush_nopush: got %b want 0", i_set1.o_valid); end
    d_set1 = mk(10'h001, 1, 30, 0, 0, 0); d_set2 = mk(10'h001, 1, 31, 0, 0, 0);
    cycle(); idle(); #1;
    if (q_count !== 2) begin n_err++; $display("FAIL rst_pre_cnt: got %0d want 2", q_count); end
    #2 rstn = 0;
    #1;
    mq.delete();
    if (q_count !== 0 || i_set1.o_valid !== 1'b0) begin n_err++; $display("FAIL async_rst: got %0d/%b want 0/0", q_count, i_set1.o_valid); end
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_random();
    PC_set e;
    for (int c = 0; c < 500; c++) begin
      d_set1 = mk_rnd($urandom_range(0, 9) < 7);
      d_set2 = mk_rnd($urandom_range(0, 1) == 1);
      flush_BR = $urandom_range(0, 39) == 0;
      stall_DCache = $urandom_range(0, 7) == 0;
      stall_div = $urandom_range(0, 7) == 0;
      #1;
      n_vec += 4;
      if (d_ready !== (mq.size() <= DEPTH - 2)) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, d_ready, mq.size() <= DEPTH - 2); end
      if (q_count !== ecnt()) begin n_err++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, q_count, ecnt()); end
      if (i_set1.o_valid !== ev1() || i_set2.o_valid !== ev2()) begin n_err++; $display("FAIL rnd_valid c%0d: got %b%b want %b%b", c, i_set1.o_valid, i_set2.o_valid, ev1(), ev2()); end
      e = mq.size() > 0 ? mq[0] : '0;
      if (ev1() && i_set1 !== e) begin n_err++; $display("FAIL rnd_set1 c%0d: got %h want %h", c, i_set1, e); end
      e = mq.size() > 1 ? mq[1] : '0;
      if (ev2() && i_set2 !== e) begin n_err++; $display("FAIL rnd_set2 c%0d: got %h want %h", c, i_set2, e); end
      cycle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_dual_alu();
    test_raw();
    test_nonalu();
    test_full();
    test_stall();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
